// File: rtl/sprite_write_scheduler.sv
// Frame-synchronous sprite register write scheduler.
// CPU writes are queued during active video and replayed to the addressed
// sprite layer, one per cycle, only while vertical blank is active.
module sprite_write_scheduler #(
  parameter int NUM_LAYERS = 20,
  parameter int DEPTH      = 32,
  parameter int V_ACTIVE   = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             writedata,
  input  logic [2:0]              address,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  output logic [NUM_LAYERS-1:0]   layer_we,
  output logic [2:0]              layer_addr,
  output logic [26:0]             layer_data,
  output logic                    frame_commit,
  output logic                    overflow,
  output logic                    bad_id,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [9:0]    VA       = 10'(V_ACTIVE);
  localparam logic [5:0]    NL       = 6'(NUM_LAYERS);

  typedef enum logic [1:0] {
    S_WAIT,
    S_DRAIN,
    S_COMMIT,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [34:0]           mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  vblank_r_q, vblank_r_d;
  logic                  vblank_q_q, vblank_q_d;
  logic [NUM_LAYERS-1:0] layer_we_q, layer_we_d;
  logic [2:0]            layer_addr_q, layer_addr_d;
  logic [26:0]           layer_data_q, layer_data_d;
  logic                  frame_commit_q, frame_commit_d;
  logic                  overflow_q, overflow_d;
  logic                  bad_id_q, bad_id_d;

  logic        push_req, ctrl_wr, flush, full, pop, push_ok;
  logic [34:0] head;
  logic [4:0]  head_id;
  logic        head_valid;
  logic        unused_hcount;

  // Decode the Avalon access and the FIFO head entry.
  always_comb begin
    push_req      = chipselect & write & (address != 3'd7);
    ctrl_wr       = chipselect & write & (address == 3'd7);
    flush         = ctrl_wr & writedata[2];
    full          = (count_q == FULL_CNT);
    head          = mem_q[rd_ptr_q];
    head_id       = head[31:27];
    head_valid    = ({1'b0, head_id} < NL);
    unused_hcount = ^hcount;
  end

  // Next-state logic: FSM, FIFO pointers/occupancy, output registers, flags.
  always_comb begin
    state_d        = state_q;
    frame_commit_d = 1'b0;
    case (state_q)
      S_WAIT:   if (vblank_r_q & ~vblank_q_q) state_d = S_DRAIN;
      S_DRAIN:  if (!vblank_r_q || count_q == '0) begin
                  state_d        = S_COMMIT;
                  frame_commit_d = 1'b1;
                end
      S_COMMIT: state_d = S_HOLD;
      S_HOLD:   if (!vblank_r_q) state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase

    // Pop only in cycles where DRAIN is not about to exit; a flush suppresses it.
    pop     = (state_q == S_DRAIN) & vblank_r_q & (count_q != '0) & ~flush;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    push_ok = push_req & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    vblank_r_d = (vcount >= VA);
    vblank_q_d = vblank_r_q;

    layer_we_d   = '0;
    layer_addr_d = layer_addr_q;
    layer_data_d = layer_data_q;
    if (pop && head_valid) begin
      layer_we_d   = NUM_LAYERS'(1) << head_id;
      layer_addr_d = head[34:32];
      layer_data_d = head[26:0];
    end

    // Clears apply first so an error seen in the same cycle is not lost.
    overflow_d = overflow_q;
    if (ctrl_wr && writedata[0]) overflow_d = 1'b0;
    if (push_req && full && !pop) overflow_d = 1'b1;

    bad_id_d = bad_id_q;
    if (ctrl_wr && writedata[1]) bad_id_d = 1'b0;
    if (pop && !head_valid) bad_id_d = 1'b1;
  end

  // FIFO storage; contents need no reset because occupancy governs validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= {address, writedata};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_WAIT;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      vblank_r_q     <= 1'b0;
      vblank_q_q     <= 1'b0;
      layer_we_q     <= '0;
      layer_addr_q   <= '0;
      layer_data_q   <= '0;
      frame_commit_q <= 1'b0;
      overflow_q     <= 1'b0;
      bad_id_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      vblank_r_q     <= vblank_r_d;
      vblank_q_q     <= vblank_q_d;
      layer_we_q     <= layer_we_d;
      layer_addr_q   <= layer_addr_d;
      layer_data_q   <= layer_data_d;
      frame_commit_q <= frame_commit_d;
      overflow_q     <= overflow_d;
      bad_id_q       <= bad_id_d;
    end
  end

  assign layer_we     = layer_we_q;
  assign layer_addr   = layer_addr_q;
  assign layer_data   = layer_data_q;
  assign frame_commit = frame_commit_q;
  assign overflow     = overflow_q;
  assign bad_id       = bad_id_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_sprite_write_scheduler.sv
// Self-checking bench for sprite_write_scheduler: directed frame scenarios
// plus randomized write bursts, scored against an in-order expected queue.
module tb_sprite_write_scheduler;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic [2:0]  address;
  logic        write;
  logic        chipselect;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [19:0] layer_we;
  logic [2:0]  layer_addr;
  logic [26:0] layer_data;
  logic        frame_commit;
  logic        overflow;
  logic        bad_id;
  logic [5:0]  fifo_count;

  sprite_write_scheduler #(
    .NUM_LAYERS(20),
    .DEPTH(32),
    .V_ACTIVE(480)
  ) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .address(address),
    .write(write), .chipselect(chipselect), .hcount(hcount), .vcount(vcount),
    .layer_we(layer_we), .layer_addr(layer_addr), .layer_data(layer_data),
    .frame_commit(frame_commit), .overflow(overflow), .bad_id(bad_id),
    .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [4:0]  id;
    logic [2:0]  addr;
    logic [26:0] pl;
  } ent_t;

  ent_t exp_q[$];
  logic exp_ovf, exp_bad;
  int   total, bad;
  int   cyc, we_cnt, commit_cnt;
  int   first_we_cyc, last_we_cyc, commit_cyc;
  logic [19:0] first_we_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and score any delivery against the expected queue.
  task automatic step();
    ent_t        e;
    logic [19:0] ew;
    @(posedge clk);
    #1;
    cyc++;
    if (|layer_we === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].id >= 5'd20) begin
        void'(exp_q.pop_front());
        exp_bad = 1'b1;
      end
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 64'(layer_we), 64'd0);
      end else begin
        e  = exp_q.pop_front();
        ew = '0;
        ew[e.id] = 1'b1;
        chk("layer_we", 64'(layer_we), 64'(ew));
        chk("layer_addr", 64'(layer_addr), 64'(e.addr));
        chk("layer_data", 64'(layer_data), 64'(e.pl));
      end
      if (first_we_cyc < 0) begin
        first_we_cyc = cyc;
        first_we_val = layer_we;
      end
      last_we_cyc = cyc;
      we_cnt++;
    end
    if (frame_commit === 1'b1) begin
      commit_cnt++;
      commit_cyc = cyc;
    end
  endtask

  task automatic drive(input logic [4:0] id, input logic [2:0] a, input logic [26:0] p);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = {id, p};
    step();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // Queued write with the model deciding acceptance (only used when no drain is running).
  task automatic wr(input logic [4:0] id, input logic [2:0] a, input logic [26:0] p);
    ent_t e;
    e = {id, a, p};
    if (exp_q.size() < 32) exp_q.push_back(e);
    else exp_ovf = 1'b1;
    drive(id, a, p);
  endtask

  task automatic rnd_wr(input int max_id);
    wr(5'($urandom_range(max_id, 0)), 3'($urandom_range(6, 0)), 27'($urandom));
  endtask

  task automatic ctrl(input logic [2:0] bits);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 3'd7;
    writedata  = {29'd0, bits};
    step();
    chipselect = 1'b0;
    write      = 1'b0;
    if (bits[0]) exp_ovf = 1'b0;
    if (bits[1]) exp_bad = 1'b0;
    if (bits[2]) exp_q.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    vcount     = 10'd100;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_bad = 1'b0;
  endtask

  // Wait (bounded) for the frame's commit pulse, then let the FSM settle back to idle.
  task automatic wait_commit(input int k0);
    int guard;
    guard = 0;
    while (commit_cnt == k0 && guard < 80) begin
      step();
      guard++;
    end
    repeat (4) step();
    chk("one_commit_per_frame", 64'(commit_cnt), 64'(k0 + 1));
  endtask

  task automatic run_vblank(input int len, output int delivered);
    int w0, k0;
    w0 = we_cnt;
    k0 = commit_cnt;
    vcount = 10'd480;
    repeat (len) step();
    vcount = 10'd100;
    wait_commit(k0);
    delivered = we_cnt - w0;
  endtask

  initial begin
    int   d, c0, w0, k0, n;
    ent_t e;
    total = 0; bad = 0; cyc = 0; we_cnt = 0; commit_cnt = 0;
    first_we_cyc = -1; last_we_cyc = -1; commit_cyc = -1;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0;
    writedata = '0; hcount = '0; vcount = '0;
    exp_ovf = 1'b0; exp_bad = 1'b0;

    // Reset state
    do_reset();
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_we", 64'(layer_we), 64'd0);
    chk("rst_addr", 64'(layer_addr), 64'd0);
    chk("rst_data", 64'(layer_data), 64'd0);
    chk("rst_commit", 64'(frame_commit), 64'd0);
    chk("rst_flags", 64'({overflow, bad_id}), 64'd0);

    // Three writes, then vblank: delivery latency, back-to-back pulses, commit after
    wr(5'd1, 3'd0, 27'h0000AA);
    wr(5'd5, 3'd1, 27'h0000BB);
    wr(5'd14, 3'd2, 27'h0000CC);
    step();
    chk("t1_count", 64'(fifo_count), 64'd3);
    first_we_cyc = -1;
    w0 = we_cnt; k0 = commit_cnt;
    c0 = cyc;
    vcount = 10'd480;
    repeat (10) step();
    chk("t1_first_latency", 64'(first_we_cyc - c0), 64'd3);
    chk("t1_first_we", 64'(first_we_val), 64'h00002);
    chk("t1_last_we", 64'(last_we_cyc - c0), 64'd5);
    chk("t1_we_cnt", 64'(we_cnt - w0), 64'd3);
    chk("t1_commit_cyc", 64'(commit_cyc - c0), 64'd6);
    vcount = 10'd100;
    wait_commit(k0);

    // 33 writes into a 32-deep FIFO: overflow, full drain in order, clear
    repeat (33) rnd_wr(19);
    chk("ovf_count", 64'(fifo_count), 64'd32);
    chk("ovf_flag", 64'(overflow), 64'(exp_ovf));
    chk("ovf_flag_set", 64'(overflow), 64'd1);
    run_vblank(40, d);
    chk("ovf_drained", 64'(d), 64'd32);
    chk("ovf_empty", 64'(fifo_count), 64'(exp_q.size()));
    ctrl(3'b001);
    chk("ovf_clear", 64'(overflow), 64'd0);

    // Invalid layer id is discarded, later entries still delivered
    rnd_wr(19);
    wr(5'd25, 3'd3, 27'h1234567);
    rnd_wr(19);
    run_vblank(10, d);
    chk("bad_delivered", 64'(d), 64'd2);
    chk("bad_flag", 64'(bad_id), 64'(exp_bad));
    chk("bad_flag_set", 64'(bad_id), 64'd1);
    chk("bad_empty", 64'(fifo_count), 64'd0);
    ctrl(3'b010);
    chk("bad_clear", 64'(bad_id), 64'd0);

    // Short vblank: only two delivered, remainder carried to next frame in order
    repeat (10) rnd_wr(19);
    run_vblank(3, d);
    chk("short_delivered", 64'(d), 64'd2);
    chk("short_left", 64'(fifo_count), 64'd8);
    chk("short_left_model", 64'(fifo_count), 64'(exp_q.size()));
    run_vblank(20, d);
    chk("short_rest", 64'(d), 64'd8);

    // Push coinciding with a pop at occupancy 1
    wr(5'd7, 3'd4, 27'h0ABCDEF);
    k0 = commit_cnt;
    vcount = 10'd480;
    step();
    step();
    e = {5'd9, 3'd5, 27'h0FEDCBA};
    exp_q.push_back(e);
    drive(5'd9, 3'd5, 27'h0FEDCBA);
    chk("pp_count", 64'(fifo_count), 64'd1);
    w0 = we_cnt;
    step();
    chk("pp_next_cycle", 64'(we_cnt - w0), 64'd1);
    chk("pp_empty", 64'(fifo_count), 64'd0);
    vcount = 10'd100;
    wait_commit(k0);

    // Full FIFO: push alongside a pop is accepted without overflow
    repeat (32) rnd_wr(19);
    chk("full_count", 64'(fifo_count), 64'd32);
    k0 = commit_cnt;
    vcount = 10'd480;
    step();
    step();
    e = {5'd3, 3'd6, 27'h0555555};
    exp_q.push_back(e);
    drive(5'd3, 3'd6, 27'h0555555);
    chk("full_pp_count", 64'(fifo_count), 64'd32);
    chk("full_pp_ovf", 64'(overflow), 64'd0);
    repeat (40) step();
    vcount = 10'd100;
    wait_commit(k0);
    chk("full_empty", 64'(fifo_count), 64'd0);
    chk("full_model_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a drain
    repeat (8) rnd_wr(19);
    w0 = we_cnt;
    vcount = 10'd480;
    repeat (5) step();
    chk("mid_partial", 64'(we_cnt - w0), 64'd3);
    reset = 1'b1;
    step();
    chk("mid_we_low", 64'(layer_we), 64'd0);
    chk("mid_count", 64'(fifo_count), 64'd0);
    reset = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; exp_bad = 1'b0;
    vcount = 10'd100;
    repeat (3) step();
    run_vblank(10, d);
    chk("mid_no_delivery", 64'(d), 64'd0);

    // Randomized bursts with occasional invalid ids, idle gaps and a flush
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(12, 0);
      for (int i = 0; i < n; i++) begin
        rnd_wr(23);
        repeat ($urandom_range(2, 0)) step();
      end
      if (r == 3) ctrl(3'b100);
      chk("rnd_count", 64'(fifo_count), 64'(exp_q.size()));
      run_vblank(30, d);
      while (exp_q.size() > 0 && exp_q[0].id >= 5'd20) begin
        void'(exp_q.pop_front());
        exp_bad = 1'b1;
      end
      chk("rnd_drained", 64'(fifo_count), 64'(exp_q.size()));
      chk("rnd_bad", 64'(bad_id), 64'(exp_bad));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
